// File: rtl/regfile_ctrl_pkg.sv
// Shared widths and write-source encoding for the register-file writeback path.
package regfile_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  // Identifies which writeback port produced the registered write.
  typedef enum logic {
    SRC_WB0 = 1'b0,
    SRC_WB1 = 1'b1
  } wb_src_e;

  // One-hot mask for a register index; used for scoreboard set/clear.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
    reg_mask = NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set when a
// long-latency op issues and cleared when its wb1 writeback reaches the regfile.
module regfile_scoreboard
  import regfile_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  output logic                  issue_ready,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_reg,
  input  logic [REG_ADDR_W-1:0] chk_reg1,
  input  logic [REG_ADDR_W-1:0] chk_reg2,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Issue handshake and decode-stage hazard lookup.
  always_comb begin
    issue_ready = !rst && !busy[issue_reg];
    hazard      = busy[chk_reg1] | busy[chk_reg2];
  end

  // Set is applied after clear so a same-cycle set on the same register wins;
  // register 0 never becomes busy.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    if (issue_valid && issue_ready && (issue_reg != '0))
      set_mask = reg_mask(issue_reg);
    if (clr_en)
      clr_mask = reg_mask(clr_reg);
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter in front of a single-write-port register file.
// wb0 (pipeline) has priority; wb1 (long-latency units) is guaranteed a slot
// after STARVE_LIMIT consecutive losses. Accepted writes are registered.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb0_valid,
  input  logic [REG_ADDR_W-1:0] wb0_reg,
  input  logic [DATA_W-1:0]     wb0_data,
  output logic                  wb0_ready,
  input  logic                  wb1_valid,
  input  logic [REG_ADDR_W-1:0] wb1_reg,
  input  logic [DATA_W-1:0]     wb1_data,
  output logic                  wb1_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] chk_reg1,
  input  logic [REG_ADDR_W-1:0] chk_reg2,
  output logic                  hazard,
  output logic                  writeenable,
  output logic [REG_ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0]     writedata
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             wb0_acc;
  logic             wb1_acc;
  wb_src_e          write_src;

  // Readies are formed from valids and the counter only, never from each other;
  // the starved term makes them mutually exclusive.
  always_comb begin
    starved   = (starve_cnt == LIMIT);
    wb1_ready = !rst && wb1_valid && (!wb0_valid || starved);
    wb0_ready = !rst && wb0_valid && !(wb1_valid && starved);
    wb0_acc   = wb0_valid && wb0_ready;
    wb1_acc   = wb1_valid && wb1_ready;
  end

  // Counts consecutive wb1 losses to wb0, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!wb1_valid || wb1_acc)
      starve_cnt <= '0;
    else if (wb0_acc && !starved)
      starve_cnt <= starve_cnt + 1'b1;
  end

  // Registered write port; writes to register 0 are consumed without enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeenable <= 1'b0;
      writereg    <= '0;
      writedata   <= '0;
      write_src   <= SRC_WB0;
    end else if (wb0_acc) begin
      writeenable <= (wb0_reg != '0);
      writereg    <= wb0_reg;
      writedata   <= wb0_data;
      write_src   <= SRC_WB0;
    end else if (wb1_acc) begin
      writeenable <= (wb1_reg != '0);
      writereg    <= wb1_reg;
      writedata   <= wb1_data;
      write_src   <= SRC_WB1;
    end else begin
      writeenable <= 1'b0;
      write_src   <= SRC_WB0;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_ready (issue_ready),
    .clr_en      (writeenable && (write_src == SRC_WB1)),
    .clr_reg     (writereg),
    .chk_reg1    (chk_reg1),
    .chk_reg2    (chk_reg2),
    .hazard      (hazard)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter with a behavioural reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_regfile_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid, issue_valid;
  logic [4:0]  wb0_reg, wb1_reg, issue_reg, chk_reg1, chk_reg2;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready, issue_ready, hazard;
  logic        writeenable;
  logic [4:0]  writereg;
  logic [31:0] writedata;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_busy [32];
  int unsigned m_starve;
  bit          m_we;
  bit          m_src_wb1;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  bit          e_wb0r, e_wb1r, e_issr, e_haz;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_reg(wb1_reg), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .hazard(hazard),
    .writeenable(writeenable), .writereg(writereg), .writedata(writedata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected combinational outputs from the arbitration and scoreboard rules.
  function automatic void calc_comb();
    e_wb1r = !rst && wb1_valid && (!wb0_valid || m_starve == LIMIT);
    e_wb0r = !rst && wb0_valid && !e_wb1r;
    e_issr = !rst && !m_busy[issue_reg];
    e_haz  = m_busy[chk_reg1] || m_busy[chk_reg2];
  endfunction

  // Advance the model across one rising edge using the inputs held at that edge.
  function automatic void model_update();
    bit a0, a1, clr;
    logic [4:0] creg;
    calc_comb();
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_starve = 0; m_we = 0; m_src_wb1 = 0; m_wreg = '0; m_wdata = '0;
      return;
    end
    a0 = wb0_valid && e_wb0r;
    a1 = wb1_valid && e_wb1r;
    clr = m_we && m_src_wb1;
    creg = m_wreg;
    if (clr) m_busy[creg] = 1'b0;
    if (issue_valid && e_issr && issue_reg != 0) m_busy[issue_reg] = 1'b1;
    if (!wb1_valid || a1) m_starve = 0;
    else if (a0 && m_starve < LIMIT) m_starve++;
    if (a0) begin
      m_we = (wb0_reg != 0); m_wreg = wb0_reg; m_wdata = wb0_data; m_src_wb1 = 0;
    end else if (a1) begin
      m_we = (wb1_reg != 0); m_wreg = wb1_reg; m_wdata = wb1_data; m_src_wb1 = 1;
    end else begin
      m_we = 0; m_src_wb1 = 0;
    end
  endfunction

  // Let inputs settle, then compare combinational outputs with the model.
  task automatic settle();
    #2;
    calc_comb();
    chk("wb0_ready", wb0_ready, e_wb0r);
    chk("wb1_ready", wb1_ready, e_wb1r);
    chk("issue_ready", issue_ready, e_issr);
    chk("hazard", hazard, e_haz);
  endtask

  // Clock edge, model advance, then compare registered outputs.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("writeenable", writeenable, m_we);
    chk("writereg", writereg, m_wreg);
    chk("writedata", writedata, m_wdata);
  endtask

  task automatic idle_inputs();
    wb0_valid = 0; wb1_valid = 0; issue_valid = 0;
    wb0_reg = '0; wb1_reg = '0; issue_reg = '0; chk_reg1 = '0; chk_reg2 = '0;
    wb0_data = '0; wb1_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    model_update();
    #1;
    settle(); step();
    chk("rst_we", writeenable, 0);
    chk("rst_wreg", writereg, 0);
    chk("rst_wdata", writedata, 0);
    rst = 1'b0;

    // Single wb0 write.
    wb0_valid = 1; wb0_reg = 5'd5; wb0_data = 32'hDEADBEEF;
    settle();
    chk("d028_wb0_ready", wb0_ready, 1);
    step();
    chk("d028_we", writeenable, 1);
    chk("d028_wreg", writereg, 5);
    chk("d028_wdata", writedata, 32'hDEADBEEF);
    idle_inputs();
    settle(); step();
    chk("d028_we_idle", writeenable, 0);
    chk("d028_wreg_hold", writereg, 5);

    // Continuous contention: wb0 wins LIMIT times, then wb1.
    wb0_valid = 1; wb1_valid = 1; wb0_reg = 5'd1; wb1_reg = 5'd2;
    for (int i = 0; i <= int'(LIMIT); i++) begin
      wb0_data = 32'h100 + i; wb1_data = 32'h200 + i;
      settle();
      chk("d029_wb0_ready", wb0_ready, (i < int'(LIMIT)) ? 1 : 0);
      chk("d029_wb1_ready", wb1_ready, (i == int'(LIMIT)) ? 1 : 0);
      step();
    end
    chk("d029_wreg", writereg, 2);
    settle();
    chk("d029_cnt_cleared", wb1_ready, 0);
    step();
    idle_inputs();
    settle(); step();

    // Issue reg 7, observe hazard through its wb1 writeback.
    issue_valid = 1; issue_reg = 5'd7;
    settle();
    chk("d030_issue_ready", issue_ready, 1);
    step();
    chk_reg1 = 5'd7;
    settle();
    chk("d030_hazard_set", hazard, 1);
    chk("d030_reissue_blocked", issue_ready, 0);
    step();
    issue_valid = 0;
    wb1_valid = 1; wb1_reg = 5'd7; wb1_data = 32'h0000_0077;
    settle();
    chk("d030_wb1_ready", wb1_ready, 1);
    step();
    wb1_valid = 0;
    settle();
    chk("d030_write_we", writeenable, 1);
    chk("d030_hazard_during", hazard, 1);
    step();
    settle();
    chk("d030_hazard_after", hazard, 0);
    step();

    // wb1 write to reg 9 lands in the same cycle reg 9 is issued: set wins.
    wb1_valid = 1; wb1_reg = 5'd9; wb1_data = 32'h99;
    settle(); step();
    wb1_valid = 0; issue_valid = 1; issue_reg = 5'd9; chk_reg1 = 5'd9;
    settle();
    chk("d031_issue_ready", issue_ready, 1);
    chk("d031_wb1_write", writeenable, 1);
    step();
    issue_valid = 0;
    settle();
    chk("d031_hazard_kept", hazard, 1);
    step();

    // Register 0: consumed silently, never busy.
    wb0_valid = 1; wb0_reg = 5'd0; wb0_data = 32'h1234;
    settle();
    chk("d032_wb0_ready", wb0_ready, 1);
    step();
    chk("d032_we", writeenable, 0);
    wb0_valid = 0; issue_valid = 1; issue_reg = 5'd0; chk_reg1 = 5'd0; chk_reg2 = 5'd0;
    settle(); step();
    issue_valid = 0;
    settle();
    chk("d032_hazard", hazard, 0);
    step();

    // Reset right after accepting a reg 3 write.
    issue_valid = 1; issue_reg = 5'd12;
    settle(); step();
    issue_valid = 0; wb0_valid = 1; wb0_reg = 5'd3; wb0_data = 32'h33;
    wb1_valid = 1; wb1_reg = 5'd4;
    settle(); step();
    rst = 1; issue_valid = 1; chk_reg1 = 5'd12;
    settle();
    chk("d033_wb0_ready", wb0_ready, 0);
    chk("d033_wb1_ready", wb1_ready, 0);
    chk("d033_issue_ready", issue_ready, 0);
    step();
    chk("d033_we", writeenable, 0);
    rst = 0; idle_inputs(); chk_reg1 = 5'd12;
    settle();
    chk("d033_busy_cleared", hazard, 0);
    step();

    // Randomised traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      wb0_valid   = ($urandom_range(0, 2) != 0);
      wb1_valid   = ($urandom_range(0, 2) != 0);
      issue_valid = ($urandom_range(0, 1) != 0);
      wb0_reg     = 5'($urandom_range(0, 15));
      wb1_reg     = 5'($urandom_range(0, 15));
      issue_reg   = 5'($urandom_range(0, 15));
      chk_reg1    = 5'($urandom_range(0, 15));
      chk_reg2    = 5'($urandom_range(0, 31));
      wb0_data    = $urandom;
      wb1_data    = $urandom;
      settle();
      chk("one_ready", {31'd0, wb0_ready && wb1_ready}, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, range 1..15: max consecutive cycles a waiting wb1 request may lose to wb0.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports wb0_valid/wb0_reg/wb0_data/wb0_ready  in/in/in/out  1/5/32/1  pipeline writeback request.
REQ-005 SHALL have ports wb1_valid/wb1_reg/wb1_data/wb1_ready  in/in/in/out  1/5/32/1  long-latency unit (mult/div/load) writeback request.
REQ-006 SHALL have ports issue_valid/issue_reg/issue_ready  in/in/out  1/5/1  marks destination of a newly issued long-latency op.
REQ-007 SHALL have ports chk_reg1/chk_reg2/hazard  in/in/out  5/5/1  decode-stage source operands and pending-write hazard flag.
REQ-008 SHALL have ports writeenable/writereg/writedata  out/out/out  1/5/32  drive the register file single write port.

Function
REQ-009 A request SHALL be accepted in a cycle where valid and ready are both 1; ready SHALL be combinational from valids, starvation counter and scoreboard, and SHALL not depend on ready of the other port.
REQ-010 At most one of wb0_ready/wb1_ready SHALL be 1 per cycle.
REQ-011 Default priority: wb0 wins; wb1_ready=1 when wb1_valid and (!wb0_valid or starve_cnt==STARVE_LIMIT).
REQ-012 starve_cnt SHALL increment when wb1_valid and wb0 accepted, SHALL clear when wb1 accepted or wb1_valid=0, and SHALL saturate at STARVE_LIMIT.
REQ-013 Accepted request SHALL appear on writeenable/writereg/writedata on the following cycle (latency 1, registered); register file latches it on that cycle's negedge.
REQ-014 Accepted request with reg 0 SHALL be consumed with writeenable=0 in the following cycle.
REQ-015 Cycles with no acceptance SHALL drive writeenable=0; writereg/writedata SHALL hold previous values.
REQ-016 Scoreboard: 32-bit busy vector; busy[0] SHALL be constant 0.
REQ-017 issue_ready = !busy[issue_reg]; busy[issue_reg] SHALL be set on posedge when issue_valid and issue_ready and issue_reg!=0.
REQ-018 busy[r] SHALL clear on the posedge ending the cycle in which writeenable=1, writereg=r and the write originated from wb1 (registered source flag).
REQ-019 Simultaneous set and clear of the same register SHALL leave busy=1 (set wins).
REQ-020 hazard = busy[chk_reg1] | busy[chk_reg2], combinational; hazard SHALL remain 1 through the cycle in which the wb1 write is presented to the register file.
REQ-021 wb1 request to a register not busy SHALL still be written; busy unaffected.
REQ-022 wb0 writes SHALL never modify busy.

Reset
REQ-023 While rst=1 at posedge: busy=0, starve_cnt=0, writeenable=0, writereg=0, writedata=0, source flag=0.
REQ-024 While rst=1, wb0_ready, wb1_ready and issue_ready SHALL be 0; requests presented during reset are not accepted.
REQ-025 Reset asserted mid-operation SHALL discard any accepted-but-unwritten request (writeenable=0 next cycle).

Structure
REQ-026 Package regfile_ctrl_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and the write-source encoding (SRC_WB0=0, SRC_WB1=1).
REQ-027 Scoreboard (REQ-016..022) SHALL be a sub-module regfile_scoreboard; arbitration, starvation counter and output register remain in top.

Verification
REQ-028 wb0 only, reg 5 data 0xDEADBEEF -> wb0_ready=1; next cycle writeenable=1, writereg=5, writedata=0xDEADBEEF.
REQ-029 wb0 and wb1 valid continuously, STARVE_LIMIT=4 -> wb0 accepted 4 cycles, wb1 accepted 5th cycle, counter back to 0.
REQ-030 issue reg 7; chk_reg1=7 -> hazard=1 next cycle; issue reg 7 again -> issue_ready=0; wb1 write reg 7 -> hazard=1 through write cycle, 0 after.
REQ-031 wb1 write to reg 9 clearing busy in same cycle as issue reg 9 -> busy[9]=1 afterwards, hazard stays 1.
REQ-032 wb0 request reg 0 data 0x1234 -> accepted, writeenable=0 next cycle; issue reg 0 -> busy unchanged, hazard=0 for chk_reg1=0.
REQ-033 rst=1 in cycle after acceptance of reg 3 write -> writeenable=0, busy=0, all readies 0 during reset.
